// File: rtl/keypad_scanner_pkg.sv
// Shared types, key map and snapshot helpers for the 4x4 hex keypad scanner.
package keypad_pkg;

   localparam int NUM_ROWS = 4;
   localparam int NUM_COLS = 4;

   typedef enum logic {
      RELEASED = 1'b0,
      PRESSED  = 1'b1
   } kp_state_e;

   // Nibble k holds the code of the key at row r, column c with k = r*4+c.
   localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

   function automatic logic [4:0] ones_count(input logic [15:0] v);
      logic [4:0] n;
      n = '0;
      for (int i = 0; i < 16; i++) begin
         n = n + 5'(v[i]);
      end
      return n;
   endfunction

   // Snapshots are stored column-major (bit c*4+r); translate to the row-major key map.
   function automatic logic [3:0] snap_code(input logic [15:0] snap);
      logic [3:0] code;
      code = '0;
      for (int c = 0; c < NUM_COLS; c++) begin
         for (int r = 0; r < NUM_ROWS; r++) begin
            if (snap[c*NUM_ROWS+r]) begin
               code = KEY_MAP[(r*NUM_COLS+c)*4 +: 4];
            end
         end
      end
      return code;
   endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchronizer; both stages reset to all ones (idle keypad rows).
module sync2 #(
   parameter int WIDTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= '1;
         sync_q <= '1;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column scan, full-frame debounce, one event per clean press,
// and an eight-digit history register for a display controller.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_PERIOD    = 100000,
   parameter int DEBOUNCE_COUNT = 4
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [3:0]  row_in,
   input  logic        clear_in,
   output logic [3:0]  col_out,
   output logic [3:0]  key_out,
   output logic        key_valid_out,
   output logic        key_held_out,
   output logic [31:0] digits_out
);

   localparam int CNT_W = $clog2(SCAN_PERIOD);
   localparam int DEB_W = $clog2(DEBOUNCE_COUNT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_PERIOD - 1);
   localparam logic [DEB_W-1:0] DEB_MAX  = DEB_W'(DEBOUNCE_COUNT);

   logic [3:0]       rows_sync;
   logic [3:0]       pressed;
   logic [CNT_W-1:0] cnt_q;
   logic [1:0]       col_q;
   logic [15:0]      work_q, work_d;
   logic [15:0]      prev_q;
   logic [DEB_W-1:0] deb_q, deb_d;
   kp_state_e        state_q;
   logic [3:0]       key_q;
   logic             valid_q;
   logic             held_q;
   logic [31:0]      digits_q;
   logic             sample;
   logic             frame_end;
   logic             stable;
   logic [3:0]       code;

   sync2 #(.WIDTH(NUM_ROWS)) u_sync (
      .clk_i  (clk_in),
      .rst_ni (rst_in),
      .d_i    (row_in),
      .q_o    (rows_sync)
   );

   assign pressed   = ~rows_sync;
   assign sample    = (cnt_q == CNT_LAST);
   assign frame_end = sample && (col_q == 2'd3);

   // work_d already contains the current column sample, so the frame-end
   // comparison sees the complete frame including column 3.
   always_comb begin
      work_d = work_q;
      if (sample) begin
         work_d[{col_q, 2'b00} +: NUM_ROWS] = pressed;
      end
      deb_d = deb_q;
      if (frame_end) begin
         if (work_d != prev_q) begin
            deb_d = DEB_W'(1);
         end else if (deb_q != DEB_MAX) begin
            deb_d = deb_q + 1'b1;
         end
      end
   end

   assign stable = frame_end && (deb_d == DEB_MAX);
   assign code   = snap_code(work_d);

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         cnt_q  <= '0;
         col_q  <= '0;
         work_q <= '0;
         prev_q <= '0;
         deb_q  <= '0;
      end else begin
         work_q <= work_d;
         if (sample) begin
            cnt_q <= '0;
            col_q <= col_q + 2'd1;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
         if (frame_end) begin
            prev_q <= work_d;
            deb_q  <= deb_d;
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q  <= RELEASED;
         key_q    <= '0;
         valid_q  <= 1'b0;
         held_q   <= 1'b0;
         digits_q <= '0;
      end else begin
         valid_q <= 1'b0;
         if (clear_in) begin
            digits_q <= '0;
         end
         if (stable) begin
            held_q <= |work_d;
            case (state_q)
               RELEASED: begin
                  if (ones_count(work_d) == 5'd1) begin
                     state_q  <= PRESSED;
                     valid_q  <= 1'b1;
                     key_q    <= code;
                     digits_q <= clear_in ? {28'd0, code} : {digits_q[27:0], code};
                  end
               end
               PRESSED: begin
                  if (work_d == '0) begin
                     state_q <= RELEASED;
                  end
               end
            endcase
         end
      end
   end

   assign col_out       = ~(4'b0001 << col_q);
   assign key_out       = key_q;
   assign key_valid_out = valid_q;
   assign key_held_out  = held_q;
   assign digits_out    = digits_q;

endmodule
